// File: rtl/gate_check_pkg.sv
// ---------------------------------------------------------------------------
// gate_check_pkg : shared FSM states and vector constants for the gate checker
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [1:0]  VEC_FIRST      = 2'b00;
    localparam logic [1:0]  VEC_LAST       = 2'b11;
    localparam int unsigned SETTLE_DEFAULT = 1;

endpackage

`default_nettype wire

// File: rtl/settle_timer.sv
// ---------------------------------------------------------------------------
// settle_timer : loadable down-counter, flags the last cycle of a settle window
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] cnt_init,
    output logic       expired
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = cnt_init;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High during the final held cycle, so the next edge leaves the window.
    assign expired = (cnt_q == 4'd1);

endmodule

`default_nettype wire

// File: rtl/gate_check_sequencer.sv
// ---------------------------------------------------------------------------
// gate_check_sequencer : walks a 2-input gate through 00..11, compares it
// against a golden model and reports error count and first failing vector.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gate_check_sequencer
    import gate_check_pkg::*;
#(
    parameter int unsigned SETTLE = SETTLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_s,
    input  logic       ref_s,
    output logic       x,
    output logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [1:0] first_fail,
    output logic       fail_valid
);

    state_e     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [2:0] err_cnt_q, err_cnt_d;
    logic [1:0] first_fail_q, first_fail_d;
    logic       fail_valid_q, fail_valid_d;
    logic       pass_q, pass_d;
    logic [1:0] xy_q, xy_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       timer_load;
    logic       timer_expired;

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .cnt_init (4'(SETTLE)),
        .expired  (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        err_cnt_d    = err_cnt_q;
        first_fail_d = first_fail_q;
        fail_valid_d = fail_valid_q;
        pass_d       = pass_q;
        timer_load   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = WAIT;
                    vec_d        = VEC_FIRST;
                    timer_load   = 1'b1;
                    err_cnt_d    = 3'd0;
                    first_fail_d = 2'b00;
                    fail_valid_d = 1'b0;
                    pass_d       = 1'b0;
                end
            end
            WAIT: begin
                if (timer_expired) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (dut_s != ref_s) begin
                    err_cnt_d = err_cnt_q + 3'd1;
                    if (!fail_valid_q) begin
                        first_fail_d = vec_q;
                        fail_valid_d = 1'b1;
                    end
                end
                // The verdict must include the mismatch of this final sample.
                if (vec_q == VEC_LAST) begin
                    state_d = DONE;
                    pass_d  = (err_cnt_d == 3'd0);
                end else begin
                    vec_d      = vec_q + 2'd1;
                    timer_load = 1'b1;
                    state_d    = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        busy_d = (state_d == WAIT) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
        xy_d   = busy_d ? vec_d : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vec_q        <= VEC_FIRST;
            err_cnt_q    <= 3'd0;
            first_fail_q <= 2'b00;
            fail_valid_q <= 1'b0;
            pass_q       <= 1'b0;
            xy_q         <= 2'b00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            err_cnt_q    <= err_cnt_d;
            first_fail_q <= first_fail_d;
            fail_valid_q <= fail_valid_d;
            pass_q       <= pass_d;
            xy_q         <= xy_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign x          = xy_q[1];
    assign y          = xy_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_cnt_q;
    assign first_fail = first_fail_q;
    assign fail_valid = fail_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_check_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gate_check_sequencer : scenario bench for gate_check_sequencer (SETTLE 1 and 3)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gate_check_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start1, start3;
    logic       use_nor;
    logic [3:0] dut_tt;

    logic       dut1_s, ref1_s, x1, y1, busy1, done1, pass1, fv1;
    logic [2:0] err1;
    logic [1:0] ff1;
    logic       dut3_s, ref3_s, x3, y3, busy3, done3, pass3, fv3;
    logic [2:0] err3;
    logic [1:0] ff3;

    // Gate under test: a single NOR, or an arbitrary truth table indexed by {x,y}.
    assign dut1_s = use_nor ? ~(x1 | y1) : dut_tt[{x1, y1}];
    assign ref1_s = ~x1 & ~y1;
    assign dut3_s = use_nor ? ~(x3 | y3) : dut_tt[{x3, y3}];
    assign ref3_s = ~x3 & ~y3;

    gate_check_sequencer #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_s(dut1_s), .ref_s(ref1_s),
        .x(x1), .y(y1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .first_fail(ff1), .fail_valid(fv1)
    );

    gate_check_sequencer #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .dut_s(dut3_s), .ref_s(ref3_s),
        .x(x3), .y(y3), .busy(busy3), .done(done3), .pass(pass3),
        .err_cnt(err3), .first_fail(ff3), .fail_valid(fv3)
    );

    int checks   = 0;
    int failures = 0;
    int sel      = 0;

    logic       cx, cy, cbusy, cdone, cpass, cfv;
    logic [2:0] cerr;
    logic [1:0] cff;

    always_comb begin
        if (sel == 1) {cx, cy, cbusy, cdone, cpass, cfv, cerr, cff} = {x3, y3, busy3, done3, pass3, fv3, err3, ff3};
        else          {cx, cy, cbusy, cdone, cpass, cfv, cerr, cff} = {x1, y1, busy1, done1, pass1, fv1, err1, ff1};
    end

    logic [1:0] o_xy   [64];
    logic       o_busy [64];
    logic       o_done [64];
    logic       o_pass [64];
    int         done_n, done_k;

    // Reference: walk the four vectors and score the gate against ~x&~y.
    int         m_err;
    logic [1:0] m_first;
    logic       m_fv, m_pass;

    task automatic model_run(input logic [3:0] tt);
        m_err = 0; m_fv = 1'b0; m_first = 2'b00;
        for (int v = 0; v < 4; v++) begin
            logic d, r;
            d = tt[v];
            r = (v == 0);
            if (d != r) begin
                m_err++;
                if (!m_fv) begin m_first = 2'(v); m_fv = 1'b1; end
            end
        end
        m_pass = (m_err == 0);
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 1) start3 = v; else start1 = v;
    endtask

    // Launch a run at edge E0; obs[k] is sampled after edge E0+k.
    task automatic capture(input int s, input int ncap, input int pulse_k, input bit hold);
        sel = s;
        @(negedge clk);
        set_start(s, 1'b1);
        @(posedge clk);
        done_n = 0;
        done_k = -1;
        for (int k = 0; k < ncap; k++) begin
            @(negedge clk);
            o_xy[k] = {cx, cy}; o_busy[k] = cbusy; o_done[k] = cdone; o_pass[k] = cpass;
            if (cdone) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            if (!hold) set_start(s, k == pulse_k);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; use_nor = 1'b1; dut_tt = 4'b0001;
        #1;
        checks++;
        if ({x1, y1, busy1, done1, pass1, err1, ff1, fv1} !== 11'd0) begin
            failures++;
            $display("FAIL reset_s1: got %b required 0", {x1, y1, busy1, done1, pass1, err1, ff1, fv1});
        end
        checks++;
        if ({x3, y3, busy3, done3, pass3, err3, ff3, fv3} !== 11'd0) begin
            failures++;
            $display("FAIL reset_s3: got %b required 0", {x3, y3, busy3, done3, pass3, err3, ff3, fv3});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_correct;
        use_nor = 1'b1;
        capture(0, 11, -1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (o_xy[k] !== 2'(k / 2) || o_busy[k] !== 1'b1) begin
                failures++;
                $display("FAIL correct_trace k=%0d: xy=%b busy=%b required xy=%b busy=1", k, o_xy[k], o_busy[k], 2'(k / 2));
            end
        end
        checks++;
        if (done_k !== 8 || done_n !== 1) begin
            failures++;
            $display("FAIL correct_done: edge=%0d count=%0d required edge=8 count=1", done_k, done_n);
        end
        checks++;
        if (o_xy[8] !== 2'b00 || o_busy[8] !== 1'b0) begin
            failures++;
            $display("FAIL correct_done_outs: xy=%b busy=%b required 00/0", o_xy[8], o_busy[8]);
        end
        checks++;
        if ({cpass, cerr, cfv} !== {1'b1, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL correct_result: pass=%b err=%0d fv=%b required 1/0/0", cpass, cerr, cfv);
        end
    endtask

    task automatic test_fault(input logic [3:0] tt, input string name);
        use_nor = 1'b0; dut_tt = tt;
        model_run(tt);
        capture(0, 11, -1, 1'b0);
        checks++;
        if (done_k !== 8 || done_n !== 1 || o_done[9] !== 1'b0) begin
            failures++;
            $display("FAIL %s_done: edge=%0d count=%0d required edge=8 count=1", name, done_k, done_n);
        end
        checks++;
        if (cerr !== 3'(m_err) || cff !== m_first || cfv !== m_fv || cpass !== m_pass) begin
            failures++;
            $display("FAIL %s_result: err=%0d ff=%b fv=%b pass=%b required %0d/%b/%b/%b",
                     name, cerr, cff, cfv, cpass, m_err, m_first, m_fv, m_pass);
        end
    endtask

    task automatic test_start_ignored;
        use_nor = 1'b1;
        capture(0, 11, 2, 1'b0);
        checks++;
        if (done_k !== 8 || done_n !== 1) begin
            failures++;
            $display("FAIL ignore_done: edge=%0d count=%0d required edge=8 count=1", done_k, done_n);
        end
        checks++;
        if (o_busy[9] !== 1'b0 || o_busy[10] !== 1'b0) begin
            failures++;
            $display("FAIL ignore_no_rerun: busy9=%b busy10=%b required 0/0", o_busy[9], o_busy[10]);
        end
    endtask

    task automatic test_back_to_back;
        bit seen;
        use_nor = 1'b1;
        capture(0, 11, -1, 1'b1);
        checks++;
        if (o_busy[9] !== 1'b0 || o_pass[9] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_idle: busy=%b pass=%b required 0/1", o_busy[9], o_pass[9]);
        end
        checks++;
        if (o_busy[10] !== 1'b1 || o_xy[10] !== 2'b00 || o_pass[10] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart: busy=%b xy=%b pass=%b required 1/00/0", o_busy[10], o_xy[10], o_pass[10]);
        end
        start1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cdone) begin seen = 1'b1; break; end
        end
        @(negedge clk);
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_done: seen=%b required 1", seen);
        end
    endtask

    task automatic test_reset_mid;
        int dn;
        use_nor = 1'b0; dut_tt = 4'b1110;
        sel = 0;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            start1 = 1'b0;
        end
        checks++;
        if ({cx, cy, cbusy, cerr} !== {2'b10, 1'b1, 3'd2}) begin
            failures++;
            $display("FAIL rstmid_pre: xy=%b busy=%b err=%0d required 10/1/2", {cx, cy}, cbusy, cerr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cx, cy, cbusy, cerr, cdone} !== 6'd0) begin
            failures++;
            $display("FAIL rstmid_async: xy=%b busy=%b err=%0d done=%b required 0", {cx, cy}, cbusy, cerr, cdone);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cdone || cbusy) dn++;
        end
        checks++;
        if (dn !== 0) begin
            failures++;
            $display("FAIL rstmid_no_done: active_cycles=%0d required 0", dn);
        end
        use_nor = 1'b1;
        capture(0, 11, -1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (o_xy[k] !== 2'(k / 2) || o_busy[k] !== 1'b1) begin
                failures++;
                $display("FAIL rstmid_rerun k=%0d: xy=%b busy=%b required xy=%b busy=1", k, o_xy[k], o_busy[k], 2'(k / 2));
            end
        end
        checks++;
        if (done_k !== 8 || cpass !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_rerun_done: edge=%0d pass=%b required 8/1", done_k, cpass);
        end
    endtask

    task automatic test_settle3;
        use_nor = 1'b1;
        capture(1, 19, -1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (o_xy[k] !== 2'(k / 4) || o_busy[k] !== 1'b1) begin
                failures++;
                $display("FAIL settle3_trace k=%0d: xy=%b busy=%b required xy=%b busy=1", k, o_xy[k], o_busy[k], 2'(k / 4));
            end
        end
        checks++;
        if (done_k !== 16 || done_n !== 1 || cpass !== 1'b1 || cerr !== 3'd0) begin
            failures++;
            $display("FAIL settle3_done: edge=%0d count=%0d pass=%b err=%0d required 16/1/1/0", done_k, done_n, cpass, cerr);
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 10; r++) begin
            int s, sv, pk;
            logic [3:0] tt;
            tt = 4'($urandom_range(0, 15));
            s  = int'($urandom_range(0, 1));
            sv = (s == 1) ? 3 : 1;
            pk = int'($urandom_range(0, 4 * (sv + 1)));
            use_nor = 1'b0; dut_tt = tt;
            model_run(tt);
            capture(s, 4 * (sv + 1) + 3, pk, 1'b0);
            checks++;
            if (done_k !== 4 * (sv + 1) || done_n !== 1 || o_busy[4 * (sv + 1) + 2] !== 1'b0) begin
                failures++;
                $display("FAIL rand%0d_done: tt=%b S=%0d pulse=%0d edge=%0d count=%0d required edge=%0d count=1",
                         r, tt, sv, pk, done_k, done_n, 4 * (sv + 1));
            end
            checks++;
            if (cerr !== 3'(m_err) || cff !== m_first || cfv !== m_fv || cpass !== m_pass) begin
                failures++;
                $display("FAIL rand%0d_result: tt=%b err=%0d ff=%b fv=%b pass=%b required %0d/%b/%b/%b",
                         r, tt, cerr, cff, cfv, cpass, m_err, m_first, m_fv, m_pass);
            end
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_fault(4'b0000, "stuck0");
        test_fault(4'b1110, "inverted");
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_settle3();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/gate_check_sequencer.md
GATE_CHECK_SEQUENCER -- requirements
Module: gate_check_sequencer

Interface
REQ-001 SHALL have parameter SETTLE, default 1, range 1..15: cycles each test vector is held before sampling.
REQ-002 SHALL have port clk, input, 1: single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: request a check run; sampled only in IDLE.
REQ-005 SHALL have port dut_s, input, 1: output of the 2-input gate under test.
REQ-006 SHALL have port ref_s, input, 1: output of the golden expression model.
REQ-007 SHALL have port x, output, 1: first stimulus input to the DUT and ref; equals vec[1].
REQ-008 SHALL have port y, output, 1: second stimulus input to the DUT and ref; equals vec[0].
REQ-009 SHALL have port busy, output, 1: high in WAIT and SAMPLE.
REQ-010 SHALL have port done, output, 1: one-cycle pulse marking run completion.
REQ-011 SHALL have port pass, output, 1: run result, held until the next accepted start.
REQ-012 SHALL have port err_cnt, output, 3: mismatch count, 0..4.
REQ-013 SHALL have port first_fail, output, 2: {x,y} of the first mismatching vector.
REQ-014 SHALL have port fail_valid, output, 1: first_fail holds a valid vector.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, SAMPLE, DONE; all outputs registered.
REQ-016 IDLE + start=1 at edge E0 SHALL: enter WAIT; set vec=00; load settle counter with SETTLE; clear err_cnt, pass, fail_valid and first_fail.
REQ-017 WAIT SHALL drive {x,y}=vec, decrement the counter each cycle and enter SAMPLE after SETTLE cycles.
REQ-018 SAMPLE SHALL compare dut_s against ref_s for one cycle.
REQ-019 On mismatch, SAMPLE SHALL increment err_cnt; if fail_valid=0 it SHALL also capture first_fail=vec and set fail_valid.
REQ-020 SAMPLE with vec!=11 SHALL increment vec, reload the counter and return to WAIT; with vec=11 it SHALL enter DONE.
REQ-021 Vector order SHALL be 00, 01, 10, 11, with no wrap-around inside a run.
REQ-022 DONE SHALL assert done for exactly one cycle, set pass=(err_cnt==0) including the final sample, and return to IDLE.
REQ-023 Timing: DONE SHALL be entered at rising edge E0+4*(SETTLE+1); for SETTLE=1 that is edge E0+8.
REQ-024 start SHALL be ignored in WAIT, SAMPLE and DONE; no queuing.
REQ-025 start held high SHALL restart a run on the first IDLE cycle after DONE.
REQ-026 In IDLE, x=y=0 SHALL hold, and pass, err_cnt, first_fail and fail_valid SHALL retain their last values.
REQ-027 err_cnt SHALL not exceed 4; no saturation logic is needed beyond 3 bits.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE, vec=00, counter=0, and x, y, busy, done, pass, err_cnt, first_fail, fail_valid all to 0.
REQ-029 Reset mid-run SHALL abort the run with no done pulse; the first start after rst_n rises SHALL begin a fresh run.

Structure
REQ-030 Package gate_check_pkg SHALL hold the state enum (IDLE, WAIT, SAMPLE, DONE), VEC_FIRST=2'b00, VEC_LAST=2'b11 and SETTLE_DEFAULT=1.
REQ-031 The settle down-counter SHALL be a sub-module settle_timer with ports clk, rst_n, load, cnt_init[3:0] and expired.
REQ-032 The FSM and result registers SHALL reside in gate_check_sequencer.

Verification
REQ-033 Correct NOR-only realisation of ~a&~b as DUT, SETTLE=1, start pulse -> x,y=00,01,10,11; done at edge 8; pass=1; err_cnt=0; fail_valid=0.
REQ-034 DUT stuck-at-0, ref=~x&~y -> err_cnt=1, first_fail=00, fail_valid=1, pass=0.
REQ-035 DUT = ~ref -> err_cnt=4, first_fail=00, pass=0; done exactly one cycle.
REQ-036 start pulsed during WAIT of vec=01 -> ignored, single done; start held high -> second run begins in the cycle after IDLE and clears pass.
REQ-037 rst_n low during WAIT of vec=10 -> same cycle x=y=0, busy=0, err_cnt=0; no done pulse; next start runs from 00.
REQ-038 SETTLE=3 with a correct DUT -> each vector held 3 cycles; done at edge 16; pass=1.
